// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline-stage register with a valid/ready handshake and a two-entry
//   skid buffer (head + skid). Any bubble presents all-zero control, so an
//   empty or flushed slot can never write architectural state downstream.
//
//   state  | meaning
//   -------+---------------------------------------------
//   EMPTY  | no valid entry; out_valid=0, out_ctrl=0
//   ONE    | head valid, skid free
//   TWO    | head and skid valid; in_ready=0
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of held entries and current input
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_ctrl/in_data   upstream control bits / payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data head control (gated to 0 when invalid) / payload
//   stall_cnt         saturating count of cycles with out_valid & !out_ready

module pipe_stage_reg #(
    parameter int CTRL_W      = 4,
    parameter int DATA_W      = 75,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [CTRL_W-1:0]      head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0]      head_data_q, head_data_d;
    logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]      skid_data_q, skid_data_d;
    logic                   in_ready_q,  in_ready_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept;
    logic pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Payload is left alone; only control must be cleared so a
            // stale entry can never be mistaken for a live one.
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end else if (accept) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready depends only on the next state, so there is no combinational
    // path from out_ready to in_ready.
    always_comb begin
        in_ready_d = (state_d != ST_TWO);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_ctrl  = out_valid ? head_ctrl_q : '0;
    assign out_data  = head_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CW = 4;
    localparam int DW = 75;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] stall_cnt;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: entries pushed on accept, popped and compared on pop.
    logic [CW+DW-1:0] sb_q[$];

    always @(posedge rst) sb_q.delete();

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_pop: got %0h expected nothing", out_data);
                end else begin
                    chk("sb_pop", 96'({out_ctrl, out_data}), 96'(sb_q.pop_front()));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
    end

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic          e_ir;
        logic [SW-1:0] e_sc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic iv, logic [CW-1:0] ic, logic [DW-1:0] id,
                                logic ordy, logic fl, logic e_ov, logic [CW-1:0] e_oc,
                                logic [DW-1:0] e_od, logic e_ir, logic [SW-1:0] e_sc);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_ir = e_ir; v.e_sc = e_sc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        chk("rst out_valid", 96'(out_valid), 96'(0));
        chk("rst out_ctrl",  96'(out_ctrl),  96'(0));
        chk("rst out_data",  96'(out_data),  96'(0));
        chk("rst in_ready",  96'(in_ready),  96'(1));
        chk("rst stall_cnt", 96'(stall_cnt), 96'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // streaming 1..8
        for (int k = 1; k <= 8; k++)
            vt.push_back(mk(1, 4'hF, DW'(k), 1, 0, 1, 4'hF, DW'(k), 1, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8, 1, 0));
        // backpressure A=2, B=4, C=5
        vt.push_back(mk(1, 4'hF, 2, 0, 0, 1, 4'hF, 2, 1, 0));
        vt.push_back(mk(1, 4'hF, 4, 0, 0, 1, 4'hF, 2, 0, 1));
        vt.push_back(mk(1, 4'hF, 5, 0, 0, 1, 4'hF, 2, 0, 2));
        vt.push_back(mk(1, 4'hF, 5, 1, 0, 1, 4'hF, 4, 1, 2));
        vt.push_back(mk(1, 4'hF, 5, 1, 0, 1, 4'hF, 5, 1, 2));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5, 1, 2));
        // flush in TWO with C offered
        vt.push_back(mk(1, 4'h3, 'hA, 0, 0, 1, 4'h3, 'hA, 1, 2));
        vt.push_back(mk(1, 4'h5, 'hB, 0, 0, 1, 4'h3, 'hA, 0, 3));
        vt.push_back(mk(1, 4'hF, 'hC, 0, 1, 0, 0, 'hA, 1, 4));
        vt.push_back(mk(1, 4'hF, 9, 0, 0, 1, 4'hF, 9, 1, 4));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9, 1, 4));
        // accept + pop in ONE
        vt.push_back(mk(1, 4'h1, 'h11, 0, 0, 1, 4'h1, 'h11, 1, 4));
        vt.push_back(mk(1, 4'h2, 7, 1, 0, 1, 4'h2, 7, 1, 4));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 7, 1, 4));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].iv, vt[i].ic, vt[i].id, vt[i].ordy, vt[i].fl);
            tick();
            chk($sformatf("v%0d out_valid", i), 96'(out_valid), 96'(vt[i].e_ov));
            chk($sformatf("v%0d out_ctrl", i),  96'(out_ctrl),  96'(vt[i].e_oc));
            chk($sformatf("v%0d out_data", i),  96'(out_data),  96'(vt[i].e_od));
            chk($sformatf("v%0d in_ready", i),  96'(in_ready),  96'(vt[i].e_ir));
            chk($sformatf("v%0d stall_cnt", i), 96'(stall_cnt), 96'(vt[i].e_sc));
        end

        // reset mid-cycle while in TWO
        drive(1, 4'h6, 'h21, 0, 0);
        tick();
        drive(1, 4'h7, 'h22, 0, 0);
        tick();
        chk("pre_rst in_ready", 96'(in_ready), 96'(0));
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst out_valid", 96'(out_valid), 96'(0));
        chk("async_rst out_ctrl",  96'(out_ctrl),  96'(0));
        chk("async_rst out_data",  96'(out_data),  96'(0));
        chk("async_rst in_ready",  96'(in_ready),  96'(1));
        chk("async_rst stall_cnt", 96'(stall_cnt), 96'(0));
        #2;
        rst = 1'b0;
        drive(1, 4'hF, 3, 0, 0);
        tick();
        chk("post_rst out_valid", 96'(out_valid), 96'(1));
        chk("post_rst out_ctrl",  96'(out_ctrl),  96'(4'hF));
        chk("post_rst out_data",  96'(out_data),  96'(3));

        // saturation: head held with out_ready=0
        drive(0, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) chk("sat14 stall_cnt", 96'(s_stall_cnt), 96'(14));
        end
        chk("sat stall_cnt", 96'(s_stall_cnt), 96'(15));
        chk("wide stall_cnt", 96'(stall_cnt), 96'(20));
        chk("sat out_valid", 96'(s_out_valid), 96'(1));
        chk("sat out_ctrl", 96'(s_out_ctrl), 96'(4'hF));
        chk("sat out_data", 96'(s_out_data), 96'(3));
        chk("sat in_ready", 96'(s_in_ready), 96'(1));
        tick();
        chk("sat hold stall_cnt", 96'(s_stall_cnt), 96'(15));
        drive(0, 0, 0, 1, 0);
        tick();
        chk("sat pop out_valid", 96'(s_out_valid), 96'(0));
        chk("sat pop stall_cnt", 96'(s_stall_cnt), 96'(15));
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("sat rst stall_cnt", 96'(s_stall_cnt), 96'(0));
        chk("wide rst stall_cnt", 96'(stall_cnt), 96'(0));
        #2;
        rst = 1'b0;
        tick();
        chk("sb empty at end", 96'(sb_q.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
